gate_sweep_checker: RTL
=======================

# gate_sweep_checker

Parametrised, synthesizable truth-table sweeper for N-input combinational gates. On `start` it drives every input vector 0 … 2^N_IN−1 onto a device under test (DUT). Each vector is held for HOLD_CYCLES clocks. At the end of each hold window the DUT output is compared against an internal reference for the selected gate function (AND/OR/XOR/XNOR). It replaces hand-written per-gate stimulus sequences and produces pass/fail, an error count and the first failing vector.

## Interface

Parameters:
- N_IN, 3, number of DUT inputs (1..8)
- HOLD_CYCLES, 4, clocks each vector is held (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a sweep; honoured in IDLE or DONE, ignored in RUN
- op  in  2  gate function: 00 AND, 01 OR, 10 XOR, 11 XNOR; latched on accepted start
- vec_out  out  N_IN  stimulus vector to DUT inputs
- dut_in  in  1  DUT output, combinational from vec_out
- busy  out  1  high in RUN
- done  out  1  high in DONE; held until next accepted start
- pass  out  1  valid when done; 1 iff err_count==0
- err_count  out  N_IN+1  number of mismatching vectors in the last sweep
- first_err_valid  out  1  at least one mismatch seen this sweep
- first_err_vec  out  N_IN  vector of first mismatch

## Operation

- All outputs reset to 0 and the state resets to IDLE.
- FSM states:
  - IDLE → RUN on start.
  - RUN → DONE after the compare of vector 2^N_IN−1.
  - DONE → RUN on start.
- Accepted start:
  - clears err_count, first_err_valid, first_err_vec, vec counter and hold counter
  - latches op
- RUN:
  - hold_cnt counts 0..HOLD_CYCLES−1.
  - When hold_cnt==HOLD_CYCLES−1, compare dut_in with expected = reduce(op_latched, vec_out).
  - On mismatch:
    - err_count increments; it is N_IN+1 bits wide, so it never saturates (max 2^N_IN).
    - If first_err_valid==0, first_err_vec captures vec_out and first_err_valid is set.
  - Then vec_out increments and hold_cnt returns to 0.
  - On the last vector, vec_out stays at all-ones and the FSM enters DONE.
- vec_out is 0 in IDLE and holds its final value (all ones) in DONE.
- start in RUN has no effect; op changes in RUN have no effect.
- An async reset mid-sweep returns the block to IDLE with all outputs 0 immediately; no partial result is retained.

## Timing

- Start sampled high at edge k: busy=1 and vec_out=0 from edge k+1.
- Each vector is present for exactly HOLD_CYCLES cycles. The compare samples dut_in at the final edge of its window.
- Sweep length: 2^N_IN × HOLD_CYCLES cycles of busy. done/pass assert on the edge that performs the last compare, the same edge busy falls.
- HOLD_CYCLES=1: compare on every edge, vector changes every cycle.
- The DUT path must settle within one cycle. Multi-cycle DUTs need a larger HOLD_CYCLES.

## Structure

- Package gate_sweep_pkg:
  - op code constants (OP_AND, OP_OR, OP_XOR, OP_XNOR)
  - state typedef (IDLE, RUN, DONE)
- Sub-module gate_ref_model: combinational, parameter N_IN, inputs vec and op, output expected. Reused by other checkers.
- Top level: FSM, hold counter, vector counter, error bookkeeping.

## Test plan

- N_IN=3, HOLD_CYCLES=4, op=XOR, DUT = correct 3-input XOR:
  - busy lasts 32 cycles; vec_out steps 0..7 every 4 cycles
  - done=1, pass=1, err_count=0, first_err_valid=0
- Same setup, DUT output stuck at 0:
  - err_count=4 (vectors 1,2,4,7 mismatch)
  - first_err_vec=3'b001, pass=0
- N_IN=4, HOLD_CYCLES=1, op=AND, DUT = OR gate:
  - mismatches on vectors 1..14: err_count=14, first_err_vec=4'b0001
- Start pulsed mid-RUN, and op changed mid-RUN:
  - sweep unaffected, results per the original op
  - then start in DONE re-clears counters and a second clean sweep passes
- rst_n low at cycle 10 of a sweep:
  - all outputs 0 immediately; busy stays 0 after release until next start
- op=XNOR, N_IN=1, DUT = inverter:
  - 2 vectors, err_count=0, pass=1
  - done held until next start

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate truth-table sweeper.
//   OP_*    : gate function codes applied on the op port
//   state_t : sweeper sequencing states
package gate_sweep_pkg;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_XNOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for an N_IN-input gate.
//   vec      : input vector applied to the gate
//   op       : gate function (AND/OR/XOR/XNOR)
//   expected : reduced gate output
module gate_ref_model
   import gate_sweep_pkg::*;
#(
   parameter int N_IN = 3
) (
   input  logic [N_IN-1:0] vec,
   input  logic [1:0]      op,
   output logic            expected
);

   always_comb begin
      expected = 1'b0;
      case (op)
         OP_AND:  expected = &vec;
         OP_OR:   expected = |vec;
         OP_XOR:  expected = ^vec;
         OP_XNOR: expected = ~(^vec);
         default: expected = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_sweep_checker.sv
// Truth-table sweeper: drives every vector 0..2^N_IN-1 onto an external gate,
// holds each for HOLD_CYCLES clocks and compares the gate output against the
// reference at the last edge of each hold window.
//   clk, rst_n      : clock, async active-low reset
//   start, op       : begin sweep (IDLE/DONE only), gate function latched on start
//   vec_out, dut_in : stimulus to the gate, gate output back
//   busy, done      : sweep running / sweep finished (held until next start)
//   pass, err_count : result of the last sweep
//   first_err_*     : first mismatching vector of the last sweep
//
// state | meaning
// IDLE  | after reset, outputs cleared, waiting for start
// RUN   | sweeping vectors, comparing at the end of each hold window
// DONE  | sweep finished, results held, vec_out stays all-ones
module gate_sweep_checker
   import gate_sweep_pkg::*;
#(
   parameter int N_IN        = 3,
   parameter int HOLD_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   output logic [N_IN-1:0] vec_out,
   input  logic            dut_in,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic            first_err_valid,
   output logic [N_IN-1:0] first_err_vec
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   state_t          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [N_IN:0]   err_q, err_d;
   logic            fev_valid_q, fev_valid_d;
   logic [N_IN-1:0] fev_q, fev_d;
   logic            expected;
   logic            window_end;
   logic            mismatch;

   gate_ref_model #(.N_IN(N_IN)) u_ref (
      .vec      (vec_q),
      .op       (op_q),
      .expected (expected)
   );

   assign window_end = (hold_q == HOLD_LAST);
   assign mismatch   = (dut_in != expected);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= 2'b00;
         vec_q       <= '0;
         hold_q      <= '0;
         err_q       <= '0;
         fev_valid_q <= 1'b0;
         fev_q       <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         vec_q       <= vec_d;
         hold_q      <= hold_d;
         err_q       <= err_d;
         fev_valid_q <= fev_valid_d;
         fev_q       <= fev_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      vec_d       = vec_q;
      hold_d      = hold_q;
      err_d       = err_q;
      fev_valid_d = fev_valid_q;
      fev_d       = fev_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = RUN;
               op_d        = op;
               vec_d       = '0;
               hold_d      = '0;
               err_d       = '0;
               fev_valid_d = 1'b0;
               fev_d       = '0;
            end
         end
         RUN: begin
            if (window_end) begin
               if (mismatch) begin
                  err_d = err_q + (N_IN+1)'(1);
                  if (!fev_valid_q) begin
                     fev_valid_d = 1'b1;
                     fev_d       = vec_q;
                  end
               end
               hold_d = '0;
               // last vector: keep all-ones on the bus while results are held
               if (vec_q == '1) state_d = DONE;
               else             vec_d   = vec_q + N_IN'(1);
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign vec_out         = vec_q;
   assign busy            = (state_q == RUN);
   assign done            = (state_q == DONE);
   assign pass            = (state_q == DONE) && (err_q == '0);
   assign err_count       = err_q;
   assign first_err_valid = fev_valid_q;
   assign first_err_vec   = fev_q;

endmodule
